// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a small byte register file, WHOAMI at 0x78 and write strobe/frame-error pulses.
// Optional SPI_SLAVE_STATUS_EN adds a saturating frame-error counter readable (write clears) at 0x7F.
module spi_slave_regfile #(
   parameter logic [7:0] WHOAMI_VALUE = 8'h5A,
   parameter int         NUM_REGS     = 16
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       CS,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   output logic       o_wr_strobe,
   output logic [6:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_frame_error
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT_CS} state_t;

   localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

   state_t      state_q, state_d;
   logic [2:0]  cs_sync_q, sclk_sync_q;
   logic [1:0]  mosi_sync_q;
   logic [7:0]  shift_q, tx_q;
   logic [3:0]  bit_cnt_q;
   logic        rw_q;
   logic [6:0]  addr_q;
   logic        miso_q;
   logic        wr_strobe_q, frame_err_q;
   logic [6:0]  wr_addr_q;
   logic [7:0]  wr_data_q;
   logic [7:0]  regs_q [NUM_REGS];
   logic [7:0]  rd_data;
   logic [7:0]  shift_next;
   logic        cs_s, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
   logic        in_frame, addr_done, frame_done, abort, wr_hit;
`ifdef SPI_SLAVE_STATUS_EN
   logic [7:0]  err_cnt_q;
`endif

   // Sync chains reset low so CS held low across reset reads as "no fall" and parks in WAIT_CS.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         cs_sync_q   <= '0;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
      end else begin
         cs_sync_q   <= {cs_sync_q[1:0], CS};
         sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
         mosi_sync_q <= {mosi_sync_q[0], MOSI};
      end
   end

   assign cs_s       = cs_sync_q[1];
   assign cs_fall    = cs_sync_q[2] & ~cs_sync_q[1];
   assign cs_rise    = ~cs_sync_q[2] & cs_sync_q[1];
   assign sclk_rise  = ~sclk_sync_q[2] & sclk_sync_q[1];
   assign sclk_fall  = sclk_sync_q[2] & ~sclk_sync_q[1];
   assign mosi_s     = mosi_sync_q[1];
   assign shift_next = {shift_q[6:0], mosi_s};

   always_ff @(posedge i_clock) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (cs_fall)    state_d = ST_ADDR;
                     else if (!cs_s) state_d = ST_WAIT_CS;
         ST_ADDR:    if (cs_rise)    state_d = ST_IDLE;
                     else if (sclk_rise && bit_cnt_q == 4'd7)  state_d = ST_DATA;
         ST_DATA:    if (cs_rise)    state_d = ST_IDLE;
                     else if (sclk_rise && bit_cnt_q == 4'd15) state_d = ST_WAIT_CS;
         ST_WAIT_CS: if (cs_rise)    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      MISO          = (state_q == ST_DATA) ? miso_q : 1'b0;
      o_wr_strobe   = wr_strobe_q;
      o_wr_addr     = wr_addr_q;
      o_wr_data     = wr_data_q;
      o_frame_error = frame_err_q;
   end

   assign in_frame   = (state_q == ST_ADDR) || (state_q == ST_DATA);
   assign addr_done  = (state_q == ST_ADDR) && (state_d == ST_DATA);
   assign frame_done = (state_q == ST_DATA) && (state_d == ST_WAIT_CS);
   // A zero bit count means CS toggled without any SCLK activity: not an error.
   assign abort      = in_frame && cs_rise && (bit_cnt_q != 4'd0);
   assign wr_hit     = frame_done && !rw_q && (addr_q < NUM_REGS_A);

   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < NUM_REGS; i++)
         if (shift_next[6:0] == 7'(i)) rd_data = regs_q[i];
      if (shift_next[6:0] == 7'h78) rd_data = WHOAMI_VALUE;
`ifdef SPI_SLAVE_STATUS_EN
      if (shift_next[6:0] == 7'h7F) rd_data = err_cnt_q;
`endif
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         shift_q     <= '0;
         tx_q        <= '0;
         bit_cnt_q   <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         miso_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      end else begin
         wr_strobe_q <= wr_hit;
         frame_err_q <= abort;
         if (state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
         end
         if (in_frame && sclk_rise && !cs_rise) begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         if (addr_done) begin
            rw_q   <= shift_next[7];
            addr_q <= shift_next[6:0];
            tx_q   <= rd_data;
         end
         if (state_q == ST_DATA && sclk_fall) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
         end
         if (wr_hit) begin
            wr_addr_q <= addr_q;
            wr_data_q <= shift_next;
            for (int i = 0; i < NUM_REGS; i++)
               if (addr_q == 7'(i)) regs_q[i] <= shift_next;
         end
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   always_ff @(posedge i_clock) begin
      if (i_reset)
         err_cnt_q <= 8'h00;
      else if (abort && err_cnt_q != 8'hFF)
         err_cnt_q <= err_cnt_q + 8'd1;
      else if (frame_done && !rw_q && addr_q == 7'h7F)
         err_cnt_q <= 8'h00;
   end
`endif

endmodule
